// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with 2-entry buffer; optional IFETCH_MISALIGN_CHECK_EN
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        ip_clk,
    input  logic        ip_reset,
    output logic [31:0] op_imem_addr,
    input  logic        ip_imem_inst_valid,
    input  logic [31:0] ip_imem_inst,
    output logic        op_inst_valid,
    output logic [31:0] op_inst,
    output logic [31:0] op_inst_pc,
    input  logic        ip_inst_ready,
    input  logic        ip_redirect_valid,
    input  logic [31:0] ip_redirect_pc,
    output logic        op_misalign_err
);

    logic [31:0] fpc;
    logic [1:0]  count;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];

    logic        halted;
    logic        redir_ok;
    logic        redir_bad;
    logic [31:0] redir_target;
    logic        push;
    logic        pop;
    logic        wr_idx;

`ifdef IFETCH_MISALIGN_CHECK_EN
    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

    mode_t mode;
    mode_t mode_next;
    logic  misalign_err;

    // Mode register: a misaligned redirect parks the unit until reset
    always_ff @(posedge ip_clk) begin
        if (ip_reset) begin
            mode <= MODE_RUN;
        end else begin
            mode <= mode_next;
        end
    end

    // Next mode: RUN -> HALT on a misaligned redirect, HALT is absorbing
    always_comb begin
        mode_next = mode;
        if (mode == MODE_RUN && ip_redirect_valid && (ip_redirect_pc[1:0] != 2'b00)) begin
            mode_next = MODE_HALT;
        end
    end

    // Sticky misalignment flag
    always_ff @(posedge ip_clk) begin
        if (ip_reset) begin
            misalign_err <= 1'b0;
        end else if (redir_bad) begin
            misalign_err <= 1'b1;
        end
    end

    assign halted          = (mode == MODE_HALT);
    assign redir_bad       = ~halted & ip_redirect_valid & (ip_redirect_pc[1:0] != 2'b00);
    assign redir_ok        = ~halted & ip_redirect_valid & (ip_redirect_pc[1:0] == 2'b00);
    assign redir_target    = ip_redirect_pc;
    assign op_misalign_err = misalign_err;
`else
    assign halted          = 1'b0;
    assign redir_bad       = 1'b0;
    assign redir_ok        = ip_redirect_valid;
    assign redir_target    = ip_redirect_pc & 32'hFFFF_FFFC;
    assign op_misalign_err = 1'b0;
`endif

    // Handshake and buffer-write control; a redirect blocks both push and pop
    always_comb begin
        op_inst_valid = (count != 2'd0) & ~ip_redirect_valid & ~halted;
        pop           = op_inst_valid & ip_inst_ready;
        push          = ~halted & ip_imem_inst_valid & ~ip_redirect_valid
                        & ((count != 2'd2) | pop);
        wr_idx        = count[1] | (count[0] & ~pop);
    end

    // Fetch PC, occupancy and buffer storage; slot 0 is always the head
    always_ff @(posedge ip_clk) begin
        if (ip_reset) begin
            fpc         <= RESET_PC;
            count       <= 2'd0;
            buf_pc[0]   <= 32'h0;
            buf_pc[1]   <= 32'h0;
            buf_inst[0] <= 32'h0;
            buf_inst[1] <= 32'h0;
        end else if (redir_ok | redir_bad) begin
            count <= 2'd0;
            if (redir_ok) begin
                fpc <= redir_target;
            end
        end else begin
            if (pop) begin
                buf_pc[0]   <= buf_pc[1];
                buf_inst[0] <= buf_inst[1];
            end
            if (push) begin
                buf_pc[wr_idx]   <= fpc;
                buf_inst[wr_idx] <= ip_imem_inst;
                fpc              <= fpc + 32'd4;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign op_imem_addr = fpc;
    assign op_inst      = buf_inst[0];
    assign op_inst_pc   = buf_pc[0];

endmodule
